// File: rtl/microondas_controle_pkg.sv
// Shared definitions for the microwave controller: state encodings and BCD
// limits used by the FSM and the program entry register.
package microondas_defs;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/microondas_controle_entry_reg.sv
// 3-digit BCD program register (M, S-tens, S-units).
// Ports:
//   clk, rst_n            clock / async active-low reset
//   clr_i                 clear all digits to 0 (wins over shift)
//   shift_i, digit_i      shift left, new digit enters the units position
//   min_o, dec_o, uni_o   held digits
//   valid_o               seconds-tens digit within 0..5
//   nonzero_o             program is not 0:00
module microondas_entry_reg
  import microondas_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       shift_i,
  input  logic [3:0] digit_i,
  output logic [3:0] min_o,
  output logic [3:0] dec_o,
  output logic [3:0] uni_o,
  output logic       valid_o,
  output logic       nonzero_o
);

  logic [3:0] min_q, dec_q, uni_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      dec_q <= '0;
      uni_q <= '0;
    end else if (clr_i) begin
      min_q <= '0;
      dec_q <= '0;
      uni_q <= '0;
    end else if (shift_i) begin
      // oldest minutes digit falls off the left
      min_q <= dec_q;
      dec_q <= uni_q;
      uni_q <= digit_i;
    end
  end

  assign min_o     = min_q;
  assign dec_o     = dec_q;
  assign uni_o     = uni_q;
  assign valid_o   = (dec_q <= SEC_TENS_MAX);
  assign nonzero_o = |{min_q, dec_q, uni_q};

endmodule

// File: rtl/microondas_controle.sv
// Microwave sequencer: keypad program entry, timer load / count gating,
// magnetron drive, door interlock, pause/resume/cancel and end-of-cook beep.
// Ports:
//   clock, Cn                       clock / async active-low reset
//   tick_1hz                        1 Hz one-cycle pulse
//   key_valid, key_code             debounced keypad digit
//   start_p, stop_p                 panel start/resume and pause/cancel pulses
//   door_open                       door level, 1 = open
//   timer_zero                      timer chain at 00:00
//   prog_min/sec_dec/sec_uni        programmed digits to timer load input
//   load_en                         timer load pulse
//   count_en                        timer decrement enable (combinational)
//   magnetron, beep, entry_err      registered panel outputs
//   state_o                         current state encoding
module microondas_controle
  import microondas_defs::*;
#(
  parameter int BEEP_TICKS = 3
) (
  input  logic       clock,
  input  logic       Cn,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start_p,
  input  logic       stop_p,
  input  logic       door_open,
  input  logic       timer_zero,
  output logic [3:0] prog_min,
  output logic [3:0] prog_sec_dec,
  output logic [3:0] prog_sec_uni,
  output logic       load_en,
  output logic       count_en,
  output logic       magnetron,
  output logic       beep,
  output logic       entry_err,
  output logic [2:0] state_o
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_q, load_d;
  logic       err_q, err_d;
  logic       settle_q;
  logic       mag_q, beep_q;
  logic       clr, shift;
  logic       prog_valid, prog_nonzero;
  logic       key_ok, zero_blind;

  microondas_entry_reg u_entry (
    .clk      (clock),
    .rst_n    (Cn),
    .clr_i    (clr),
    .shift_i  (shift),
    .digit_i  (key_code),
    .min_o    (prog_min),
    .dec_o    (prog_sec_dec),
    .uni_o    (prog_sec_uni),
    .valid_o  (prog_valid),
    .nonzero_o(prog_nonzero)
  );

  assign key_ok     = key_valid && (key_code <= BCD_MAX);
  // timer outputs are stale during the load cycle and the one after it
  assign zero_blind = load_q | settle_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    clr     = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (stop_p) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
        end else if (start_p) begin
          // from IDLE an empty program makes start a no-op, not an error
          if (!door_open && (state_q == ST_ENTRY || prog_nonzero)) begin
            if (prog_valid && prog_nonzero) begin
              load_d  = 1'b1;
              state_d = ST_COOK;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (key_ok) begin
          shift   = 1'b1;
          state_d = ST_ENTRY;
        end
      end
      ST_COOK: begin
        if (door_open || stop_p)         state_d = ST_PAUSE;
        else if (timer_zero && !zero_blind) state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (stop_p) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
        end else if (start_p && !door_open) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (door_open || stop_p || key_valid) begin
          state_d = ST_IDLE;
        end else if (tick_1hz) begin
          if (cnt_q == 4'(BEEP_TICKS - 1)) state_d = ST_IDLE;
          else                              cnt_d   = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != ST_DONE) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge Cn) begin
    if (!Cn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      settle_q <= 1'b0;
      err_q    <= 1'b0;
      mag_q    <= 1'b0;
      beep_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      settle_q <= load_q;
      err_q    <= err_d;
      mag_q    <= (state_d == ST_COOK);
      beep_q   <= (state_d == ST_DONE);
    end
  end

  // combinational so a tick arriving with the door opening is dropped
  assign count_en  = tick_1hz & (state_q == ST_COOK) & ~door_open;
  assign load_en   = load_q;
  assign entry_err = err_q;
  assign magnetron = mag_q;
  assign beep      = beep_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_microondas_controle.sv
`timescale 1ns/1ps
module tb_microondas_controle;

  localparam int BT = 3;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;

  logic       clock = 1'b0;
  logic       Cn = 1'b0;
  logic       tick_1hz = 0, key_valid = 0, start_p = 0, stop_p = 0;
  logic       door_open = 0, timer_zero = 0;
  logic [3:0] key_code = '0;
  logic [3:0] prog_min, prog_sec_dec, prog_sec_uni;
  logic       load_en, count_en, magnetron, beep, entry_err;
  logic [2:0] state_o;

  microondas_controle #(.BEEP_TICKS(BT)) dut (
    .clock(clock), .Cn(Cn), .tick_1hz(tick_1hz), .key_valid(key_valid),
    .key_code(key_code), .start_p(start_p), .stop_p(stop_p),
    .door_open(door_open), .timer_zero(timer_zero),
    .prog_min(prog_min), .prog_sec_dec(prog_sec_dec), .prog_sec_uni(prog_sec_uni),
    .load_en(load_en), .count_en(count_en), .magnetron(magnetron), .beep(beep),
    .entry_err(entry_err), .state_o(state_o)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic cen_s;

  typedef struct {
    logic kv; logic [3:0] kc; logic st, sp, door, tz, tick;
    int s, m, d, u, ld, cen, mag, bp, err;
  } vec_t;
  vec_t tbl[$];

  // behavioural model state
  int md, dg[3], blind, beeps_left;
  int e_ld, e_err, e_cen;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int s, m, d, u, ld, cen, mag, bp, err);
    chk({tag, " state"}, int'(state_o), s);
    chk({tag, " prog_min"}, int'(prog_min), m);
    chk({tag, " prog_sec_dec"}, int'(prog_sec_dec), d);
    chk({tag, " prog_sec_uni"}, int'(prog_sec_uni), u);
    chk({tag, " load_en"}, int'(load_en), ld);
    chk({tag, " count_en"}, int'(cen_s), cen);
    chk({tag, " magnetron"}, int'(magnetron), mag);
    chk({tag, " beep"}, int'(beep), bp);
    chk({tag, " entry_err"}, int'(entry_err), err);
  endtask

  // inputs set at negedge, count_en sampled mid-low-phase, registered outputs #1 after posedge
  task automatic cyc(input logic kv, input logic [3:0] kc, input logic st, sp, door, tz, tick);
    @(negedge clock);
    key_valid = kv; key_code = kc; start_p = st; stop_p = sp;
    door_open = door; timer_zero = tz; tick_1hz = tick;
    #1 cen_s = count_en;
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t v(input logic kv, input logic [3:0] kc, input logic st, sp, door, tz, tick,
                             input int s, m, d, u, ld, cen, mag, bp, err);
    vec_t r;
    r.kv = kv; r.kc = kc; r.st = st; r.sp = sp; r.door = door; r.tz = tz; r.tick = tick;
    r.s = s; r.m = m; r.d = d; r.u = u; r.ld = ld; r.cen = cen; r.mag = mag; r.bp = bp; r.err = err;
    return r;
  endfunction

  task automatic model_reset();
    md = M_IDLE; dg[0] = 0; dg[1] = 0; dg[2] = 0; blind = 0; beeps_left = 0;
    e_ld = 0; e_err = 0; e_cen = 0;
  endtask

  // one clock of the reference: rules taken from the behaviour description
  task automatic model_step(input int kv, kc, st, sp, door, tz, tick);
    int total; bit ign;
    total = dg[0] * 100 + dg[1] * 10 + dg[2];
    e_cen = (tick && md == M_COOK && !door) ? 1 : 0;
    e_ld = 0; e_err = 0;
    ign = (blind > 0);
    if (blind > 0) blind--;
    case (md)
      M_IDLE, M_ENTRY: begin
        if (sp) begin
          dg[0] = 0; dg[1] = 0; dg[2] = 0; md = M_IDLE;
        end else if (st) begin
          if (!door && (md == M_ENTRY || total != 0)) begin
            if (dg[1] <= 5 && total != 0) begin
              md = M_COOK; e_ld = 1; blind = 2;
            end else e_err = 1;
          end
        end else if (kv && kc <= 9) begin
          dg[0] = dg[1]; dg[1] = dg[2]; dg[2] = kc; md = M_ENTRY;
        end
      end
      M_COOK: begin
        if (door || sp) md = M_PAUSE;
        else if (tz && !ign) begin md = M_DONE; beeps_left = BT; end
      end
      M_PAUSE: begin
        if (sp) begin dg[0] = 0; dg[1] = 0; dg[2] = 0; md = M_IDLE; end
        else if (st && !door) md = M_COOK;
      end
      default: begin
        if (door || sp || kv) md = M_IDLE;
        else if (tick) begin
          beeps_left--;
          if (beeps_left == 0) md = M_IDLE;
        end
      end
    endcase
  endtask

  initial begin
    // reset state
    #12;
    cen_s = count_en;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); Cn = 1'b1;

    //               kv kc  st sp dr tz tk   s  m  d  u  ld cen mag bp err
    tbl.push_back(v(1, 1,  0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 3,  0, 0, 0, 0, 0,   1, 0, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0,  0, 0, 0, 0, 0,   1, 1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 12, 0, 0, 0, 0, 0,   1, 1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,  1, 0, 0, 0, 0,   2, 1, 3, 0, 1, 0, 1, 0, 0));
    tbl.push_back(v(0, 0,  0, 0, 0, 1, 1,   2, 1, 3, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(0, 0,  0, 0, 0, 1, 0,   2, 1, 3, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0,  0, 0, 1, 0, 1,   3, 1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,  1, 0, 0, 0, 0,   2, 1, 3, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0,  0, 0, 0, 1, 0,   4, 1, 3, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0,  0, 0, 0, 0, 1,   4, 1, 3, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0,  0, 0, 0, 0, 1,   4, 1, 3, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0,  0, 0, 0, 0, 1,   0, 1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,  1, 0, 0, 0, 0,   2, 1, 3, 0, 1, 0, 1, 0, 0));
    tbl.push_back(v(0, 0,  0, 1, 0, 0, 0,   3, 1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,  0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,  1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 7,  0, 0, 0, 0, 0,   1, 0, 0, 7, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 5,  0, 0, 0, 0, 0,   1, 0, 7, 5, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,  1, 0, 0, 0, 0,   1, 0, 7, 5, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0,  0, 0, 0, 0, 0,   1, 0, 7, 5, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,  1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,  1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 5,  0, 0, 1, 0, 0,   1, 0, 0, 5, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,  1, 0, 1, 0, 0,   1, 0, 0, 5, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,  1, 0, 0, 0, 0,   2, 0, 0, 5, 1, 0, 1, 0, 0));
    tbl.push_back(v(0, 0,  0, 1, 0, 0, 0,   3, 0, 0, 5, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,  1, 0, 1, 0, 0,   3, 0, 0, 5, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,  1, 0, 0, 0, 0,   2, 0, 0, 5, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0,  0, 0, 0, 1, 0,   4, 0, 0, 5, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 3,  0, 0, 0, 0, 0,   0, 0, 0, 5, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,  0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].kv, tbl[i].kc, tbl[i].st, tbl[i].sp, tbl[i].door, tbl[i].tz, tbl[i].tick);
      chk_all($sformatf("vec%0d", i), tbl[i].s, tbl[i].m, tbl[i].d, tbl[i].u,
              tbl[i].ld, tbl[i].cen, tbl[i].mag, tbl[i].bp, tbl[i].err);
    end

    // asynchronous reset in the middle of cooking
    cyc(1, 2, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("pre-reset magnetron", int'(magnetron), 1);
    @(negedge clock); #2 Cn = 1'b0;
    #1 cen_s = count_en;
    chk_all("async reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); Cn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 1);
      chk_all($sformatf("post-reset%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // randomized run against the reference model
    @(negedge clock); Cn = 1'b0;
    @(negedge clock); Cn = 1'b1;
    model_reset();
    begin
      logic dr;
      dr = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        logic kv, st, sp, tz, tk;
        logic [3:0] kc;
        kv = ($urandom_range(0, 3) == 0);
        kc = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 11));
        st = ($urandom_range(0, 6) == 0);
        sp = ($urandom_range(0, 24) == 0);
        tz = ($urandom_range(0, 9) == 0);
        tk = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 19) == 0) dr = ~dr;
        cyc(kv, kc, st, sp, dr, tz, tk);
        model_step(int'(kv), int'(kc), int'(st), int'(sp), int'(dr), int'(tz), int'(tk));
        chk_all($sformatf("rnd%0d", i), md, dg[0], dg[1], dg[2], e_ld, e_cen,
                (md == M_COOK) ? 1 : 0, (md == M_DONE) ? 1 : 0, e_err);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
